cerr_thresh_ctrl: RTL

CERR_THRESH_CTRL -- requirements
Module: cerr_thresh_ctrl

---
 rtl/cerr_pkg.sv | 17 +
 rtl/cerr_thresh_ctrl_if.sv | 21 ++
 rtl/cerr_sat_cnt.sv | 31 +++
 rtl/cerr_thresh_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/cerr_pkg.sv
// Shared types and constants for the correctable-error threshold controller.
package cerr_pkg;

   localparam int CERR_THR_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } cerr_hs_state_e;

   // A zero threshold disables the interrupt; counting still proceeds.
   function automatic logic thresh_reached(input logic [CERR_THR_W-1:0] count,
                                           input logic [CERR_THR_W-1:0] thresh);
      return (thresh != '0) && (count >= thresh);
   endfunction

endpackage

// File: rtl/cerr_thresh_ctrl_if.sv
// Four-phase threshold programming handshake between an initiator and the controller.
interface cerr_thresh_ctrl_if;
   import cerr_pkg::*;

   logic                  cerr_threshold_vld;
   logic [CERR_THR_W-1:0] cerr_threshold;
   logic                  cerr_threshold_ack;

   modport master (
      output cerr_threshold_vld,
      output cerr_threshold,
      input  cerr_threshold_ack
   );

   modport slave (
      input  cerr_threshold_vld,
      input  cerr_threshold,
      output cerr_threshold_ack
   );

endinterface

// File: rtl/cerr_sat_cnt.sv
// Saturating up-counter with synchronous clear; also exposes its next value.
module cerr_sat_cnt
   import cerr_pkg::*;
(
   input  logic                  bist_clk,
   input  logic                  reset_n,
   input  logic                  clr,
   input  logic                  inc,
   output logic [CERR_THR_W-1:0] count_q,
   output logic [CERR_THR_W-1:0] count_nxt
);

   // Clear wins over increment; at all-ones the count holds instead of wrapping.
   always_comb begin
      count_nxt = count_q;
      if (clr) begin
         count_nxt = '0;
      end else if (inc && (count_q != '1)) begin
         count_nxt = count_q + 1'b1;
      end
   end

   always_ff @(posedge bist_clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_nxt;
      end
   end

endmodule

// File: rtl/cerr_thresh_ctrl.sv
// Correctable-error counter with a handshake-programmed threshold and sticky interrupt.
module cerr_thresh_ctrl
   import cerr_pkg::*;
#(
   parameter logic [CERR_THR_W-1:0] RESET_THRESHOLD = 8'h10
) (
   input  logic                  bist_clk,
   input  logic                  reset_n,
   cerr_thresh_ctrl_if.slave     prog,
   input  logic                  cerr_event,
   input  logic                  cerr_int_clr,
   output logic [CERR_THR_W-1:0] cerr_thresh_q,
   output logic [CERR_THR_W-1:0] cerr_count,
   output logic                  cerr_int
);

   cerr_hs_state_e        state_q;
   logic                  ack_q;
   logic                  capture;
   logic                  cnt_clr;
   logic                  cnt_inc;
   logic [CERR_THR_W-1:0] count_nxt;

   // A request is only accepted from IDLE; capture outranks clear, which outranks events.
   assign capture = (state_q == IDLE) && prog.cerr_threshold_vld;
   assign cnt_clr = capture || cerr_int_clr;
   assign cnt_inc = cerr_event && !cnt_clr;

   assign prog.cerr_threshold_ack = ack_q;

   always_ff @(posedge bist_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ack_q         <= 1'b0;
         cerr_thresh_q <= RESET_THRESHOLD;
      end else begin
         case (state_q)
            IDLE: begin
               if (prog.cerr_threshold_vld) begin
                  cerr_thresh_q <= prog.cerr_threshold;
                  ack_q         <= 1'b1;
                  state_q       <= ACK;
               end
            end
            ACK: begin
               if (!prog.cerr_threshold_vld) begin
                  ack_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               ack_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   cerr_sat_cnt u_sat_cnt (
      .bist_clk  (bist_clk),
      .reset_n   (reset_n),
      .clr       (cnt_clr),
      .inc       (cnt_inc),
      .count_q   (cerr_count),
      .count_nxt (count_nxt)
   );

   // Interrupt is sticky until a clear or a new threshold capture.
   always_ff @(posedge bist_clk or negedge reset_n) begin
      if (!reset_n) begin
         cerr_int <= 1'b0;
      end else if (cnt_clr) begin
         cerr_int <= 1'b0;
      end else if (thresh_reached(count_nxt, cerr_thresh_q)) begin
         cerr_int <= 1'b1;
      end
   end

endmodule
